// File: rtl/fir_diff_tap_line.sv
// Sample delay line and antisymmetric pre-subtraction for the order-9 differentiating FIR.
// Emits TAPS/2 exact tap-pair differences per accepted sample, once the line has filled.
module fir_diff_tap_line #(
    parameter int DATA_WIDTH = 14,
    parameter int TAPS       = 10,
    parameter int PAIRS      = TAPS / 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [PAIRS*(DATA_WIDTH+1)-1:0]    out_pair
);

    localparam int PW    = DATA_WIDTH + 1;
    localparam int CNT_W = $clog2(TAPS + 1);
    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(TAPS - 1);

    logic [DATA_WIDTH-1:0] tap_r     [TAPS];
    logic [DATA_WIDTH-1:0] shifted_s [TAPS];
    logic [CNT_W-1:0]      fill_cnt_r;
    logic                  out_valid_r;
    logic [PAIRS*PW-1:0]   out_pair_r;
    logic [PAIRS*PW-1:0]   pairs_s;
    logic                  in_ready_s;
    logic                  accept_s;
    logic                  primed_s;

    function automatic logic [PW-1:0] sext(input logic [DATA_WIDTH-1:0] v);
        return {v[DATA_WIDTH-1], v};
    endfunction

    // Accept only when the held output is empty or being drained this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst || clear) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = !out_valid_r || out_ready;
        end
    end

    assign accept_s = in_valid && in_ready_s;
    // Primed when this accept completes the fill, or the line is already full.
    assign primed_s = (fill_cnt_r >= FILL_LAST);

    // Post-shift view of the line, with the incoming sample standing in as tap[0].
    always_comb begin
        shifted_s[0] = in_data;
        for (int i = 1; i < TAPS; i++) begin
            shifted_s[i] = tap_r[i-1];
        end
    end

    // One extra bit makes every pair difference exact.
    always_comb begin
        pairs_s = '0;
        for (int k = 0; k < PAIRS; k++) begin
            pairs_s[k*PW +: PW] = sext(shifted_s[k]) - sext(shifted_s[TAPS-1-k]);
        end
    end

    // Delay line and fill counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_r      <= '{default: '0};
            fill_cnt_r <= '0;
        end else if (clear) begin
            tap_r      <= '{default: '0};
            fill_cnt_r <= '0;
        end else if (accept_s) begin
            tap_r <= shifted_s;
            if (fill_cnt_r != FILL_FULL) begin
                fill_cnt_r <= fill_cnt_r + CNT_W'(1);
            end
        end
    end

    // Output register: a primed accept reloads, otherwise a drain empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_pair_r  <= '0;
        end else if (clear) begin
            out_valid_r <= 1'b0;
        end else if (accept_s && primed_s) begin
            out_valid_r <= 1'b1;
            out_pair_r  <= pairs_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_pair  = out_pair_r;

endmodule

// File: tb/tb_fir_diff_tap_line.sv
// Bench for fir_diff_tap_line: directed scenarios with literal expectations plus a
// sample-history model checked against the outputs on every cycle.
module tb_fir_diff_tap_line;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [13:0] in_data = 14'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [74:0] out_pair;

    int total = 0;
    int bad = 0;

    fir_diff_tap_line dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pair(out_pair)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pair_of(input logic [74:0] v, input int k);
        logic signed [14:0] p;
        p = v[k*15 +: 15];
        return int'(p);
    endfunction

    // Model: recent accepted samples, newest first; history restarts on reset/clear.
    int hist[$];
    int exp_pair[5];
    bit exp_valid = 1'b0;
    int acc_total = 0;
    int xfer_total = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            hist.delete();
            exp_valid = 1'b0;
            for (int k = 0; k < 5; k++) exp_pair[k] = 0;
        end else if (clear) begin
            hist.delete();
            exp_valid = 1'b0;
        end else begin
            bit acc;
            acc = in_valid && (!exp_valid || out_ready);
            if (acc) begin
                hist.push_front(int'($signed(in_data)));
                if (hist.size() > 10) void'(hist.pop_back());
                acc_total++;
            end
            if (acc && hist.size() == 10) begin
                for (int k = 0; k < 5; k++) exp_pair[k] = hist[k] - hist[9-k];
                exp_valid = 1'b1;
            end else if (exp_valid && out_ready) begin
                exp_valid = 1'b0;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        if (out_valid && out_ready) xfer_total++;
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("in_ready", int'(in_ready), int'(!rst && !clear && (!exp_valid || out_ready)));
        check("out_valid", int'(out_valid), int'(exp_valid));
        if (exp_valid) begin
            for (int k = 0; k < 5; k++)
                check($sformatf("pair%0d", k), pair_of(out_pair, k), exp_pair[k]);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input int d);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data = 14'(d);
        for (int w = 0; w < 50 && !done; w++) begin
            #1;
            if (in_ready) done = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for sample %0d", d);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
    endtask

    task automatic chk_pairs(input string tag, input int e0, input int e1, input int e2,
                             input int e3, input int e4);
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_p0"}, pair_of(out_pair, 0), e0);
        check({tag, "_p1"}, pair_of(out_pair, 1), e1);
        check({tag, "_p2"}, pair_of(out_pair, 2), e2);
        check({tag, "_p3"}, pair_of(out_pair, 3), e3);
        check({tag, "_p4"}, pair_of(out_pair, 4), e4);
    endtask

    initial begin
        int acc_base;
        int xfer_base;
        int cycles;

        idle(2);
        rst = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pair0", pair_of(out_pair, 0), 0);

        // Priming ramp 1..10, then 11.
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) send(i);
        check("prime_no_valid", int'(out_valid), 0);
        send(10);
        chk_pairs("ramp10", 9, 7, 5, 3, 1);
        send(11);
        chk_pairs("ramp11", 9, 7, 5, 3, 1);

        // Backpressure: three stalled cycles, then full-rate streaming.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 14'd12;
        repeat (3) begin
            #1;
            check("bp_in_ready", int'(in_ready), 0);
            @(negedge clk);
            #1;
            check("bp_hold_p0", pair_of(out_pair, 0), 9);
        end
        out_ready = 1'b1;
        for (int i = 12; i <= 20; i++) begin
            in_data = 14'(i);
            idle(1);
        end
        in_valid = 1'b0;
        chk_pairs("stream20", 9, 7, 5, 3, 1);

        // Clear with a sample presented: sample dropped, priming restarts.
        in_valid = 1'b1;
        in_data = 14'd777;
        clear = 1'b1;
        #1;
        check("clr_in_ready", int'(in_ready), 0);
        idle(1);
        clear = 1'b0;
        in_valid = 1'b0;
        check("clr_out_valid", int'(out_valid), 0);
        for (int i = 1; i <= 9; i++) send(10 * i);
        check("clr_prime_no_valid", int'(out_valid), 0);
        send(100);
        chk_pairs("clr_fresh", 90, 70, 50, 30, 10);

        // Extremes: exact +/-16383 without wrap.
        pulse_clear();
        send(-8192);
        for (int i = 0; i < 8; i++) send(0);
        send(8191);
        chk_pairs("ext_pos", 16383, 0, 0, 0, 0);
        pulse_clear();
        send(8191);
        for (int i = 0; i < 8; i++) send(0);
        send(-8192);
        chk_pairs("ext_neg", -16383, 0, 0, 0, 0);

        // Asynchronous reset while an output is held.
        pulse_clear();
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) send(i);
        check("pre_rst_valid", int'(out_valid), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_in_ready", int'(in_ready), 0);
        for (int k = 0; k < 5; k++) check($sformatf("arst_pair%0d", k), pair_of(out_pair, k), 0);
        idle(2);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) send(i + 30);
        check("rst_prime_no_valid", int'(out_valid), 0);
        send(40);
        chk_pairs("rst_reprime", 9, 7, 5, 3, 1);

        // Random stream with random handshakes.
        pulse_clear();
        acc_base = acc_total;
        xfer_base = xfer_total;
        cycles = 0;
        while (acc_total - acc_base < 10000 && cycles < 60000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = 14'($urandom_range(0, 16383));
            out_ready = ($urandom_range(0, 3) != 0);
            idle(1);
            cycles++;
        end
        if (cycles >= 60000) begin
            total++;
            bad++;
            $display("FAIL rand_budget: accepts %0d required 10000", acc_total - acc_base);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(3);
        check("rand_out_count", xfer_total - xfer_base, (acc_total - acc_base) - 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
